// File: rtl/vu_level_meter.sv
// VU level meter: turns a stream of signed 12-bit audio samples into a
// display-ready level. The level attacks instantly and decays linearly on
// each tick. A peak marker holds for a while before it follows the level
// down, and a sticky flag records clipping. Outputs drive an 8-LED
// thermometer bar and a one-hot peak LED.
module vu_level_meter #(
    parameter logic [10:0] DECAY      = 11'd16,
    parameter logic [7:0]  HOLD_TICKS = 8'd50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        clip_clr,
    output logic [7:0]  bar,
    output logic [7:0]  peak_led,
    output logic        clip,
    output logic [10:0] level
);

    localparam logic [10:0] MAG_MAX = 11'h7FF;

    // Number of LEDs lit for a value: 0 for zero, otherwise the top three
    // bits plus one, so 1..255 lights one LED and 1792..2047 lights all eight.
    function automatic logic [3:0] lit_count(input logic [10:0] v);
        logic [3:0] n;
        if (v == 11'd0) begin
            n = 4'd0;
        end else begin
            n = {1'b0, v[10:8]} + 4'd1;
        end
        return n;
    endfunction

    logic [10:0] level_q, level_d;
    logic [10:0] peak_q, peak_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  bar_q, bar_d;
    logic [7:0]  peak_led_q, peak_led_d;
    logic        clip_q, clip_d;

    logic [10:0] mag;
    logic [11:0] sample_neg;
    logic [10:0] decayed;

    // Magnitude of the incoming sample; -2048 has no positive twin in
    // 12 bits, so it saturates to the largest 11-bit value.
    always_comb begin
        mag        = 11'd0;
        sample_neg = (~sample) + 12'd1;
        if (sample_valid) begin
            if (!sample[11]) begin
                mag = sample[10:0];
            end else if (sample == 12'h800) begin
                mag = MAG_MAX;
            end else begin
                mag = sample_neg[10:0];
            end
        end
    end

    // Level: decay first on a tick (clamped at zero), then let a louder
    // sample take over immediately.
    always_comb begin
        decayed = level_q;
        if (tick) begin
            decayed = (level_q > DECAY) ? (level_q - DECAY) : 11'd0;
        end
        level_d = (mag > decayed) ? mag : decayed;
    end

    // Peak marker: a new maximum restarts the hold timer and wins over the
    // tick; once the timer has run out the marker tracks the level down.
    always_comb begin
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;
        if (level_d > peak_q) begin
            peak_d     = level_d;
            hold_cnt_d = HOLD_TICKS;
        end else if (tick && (hold_cnt_q != 8'd0)) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
        end else if (tick) begin
            peak_d = level_d;
        end
    end

    // LED patterns come from the registered level and peak, which adds one
    // cycle of latency but keeps the display path short.
    always_comb begin
        logic [3:0] n_level;
        logic [3:0] n_peak;
        logic [8:0] therm;
        n_level    = lit_count(level_q);
        n_peak     = lit_count(peak_q);
        therm      = (9'd1 << n_level) - 9'd1;
        bar_d      = therm[7:0];
        peak_led_d = 8'd0;
        if (n_peak != 4'd0) begin
            peak_led_d = 8'd1 << (n_peak - 4'd1);
        end
    end

    // Sticky clip flag: a full-scale sample sets it, and setting beats a
    // simultaneous clear so no clip event is ever lost.
    always_comb begin
        clip_d = clip_q;
        if (sample_valid && (mag == MAG_MAX)) begin
            clip_d = 1'b1;
        end else if (clip_clr) begin
            clip_d = 1'b0;
        end
    end

    // State registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= 11'd0;
            peak_q     <= 11'd0;
            hold_cnt_q <= 8'd0;
            bar_q      <= 8'd0;
            peak_led_q <= 8'd0;
            clip_q     <= 1'b0;
        end else begin
            level_q    <= level_d;
            peak_q     <= peak_d;
            hold_cnt_q <= hold_cnt_d;
            bar_q      <= bar_d;
            peak_led_q <= peak_led_d;
            clip_q     <= clip_d;
        end
    end

    assign bar      = bar_q;
    assign peak_led = peak_led_q;
    assign clip     = clip_q;
    assign level    = level_q;

endmodule

// File: tb/tb_vu_level_meter.sv
// Testbench for vu_level_meter: directed vector table, hand-written
// decay/hold sequences, then randomized traffic against a reference model.
module tb_vu_level_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        sample_valid;
    logic [11:0] sample;
    logic        clip_clr;
    logic [7:0]  bar;
    logic [7:0]  peak_led;
    logic        clip;
    logic [10:0] level;

    int checks = 0;
    int errors = 0;

    // Reference model state, in plain integers.
    int m_level, m_peak, m_hold, m_clip, m_bar, m_led;

    vu_level_meter dut (
        .clk(clk), .rst(rst), .tick(tick), .sample_valid(sample_valid),
        .sample(sample), .clip_clr(clip_clr), .bar(bar), .peak_led(peak_led),
        .clip(clip), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        tick;
        logic        valid;
        logic [11:0] smp;
        logic        clr;
        logic [10:0] e_level;
        logic [7:0]  e_bar;
        logic [7:0]  e_led;
        logic        e_clip;
    } vec_t;

    vec_t vecs[20];

    function automatic int lit_n(input int v);
        return (v == 0) ? 0 : (v / 256) + 1;
    endfunction

    function automatic int therm_of(input int v);
        int r = 0;
        for (int i = 0; i < lit_n(v); i++) r = r | (1 << i);
        return r;
    endfunction

    function automatic int onehot_of(input int v);
        return (lit_n(v) == 0) ? 0 : (1 << (lit_n(v) - 1));
    endfunction

    // Advance the reference model by one clock using the current inputs.
    task automatic modelStep();
        int s, mag, dec, nl;
        if (rst) begin
            m_level = 0; m_peak = 0; m_hold = 0; m_clip = 0; m_bar = 0; m_led = 0;
            return;
        end
        s   = sample[11] ? int'(sample) - 4096 : int'(sample);
        mag = 0;
        if (sample_valid) mag = (s < 0) ? ((-s > 2047) ? 2047 : -s) : s;
        dec = m_level;
        if (tick) dec = (m_level > 16) ? m_level - 16 : 0;
        nl    = (mag > dec) ? mag : dec;
        m_bar = therm_of(m_level);
        m_led = onehot_of(m_peak);
        if (nl > m_peak) begin
            m_peak = nl; m_hold = 50;
        end else if (tick && m_hold > 0) begin
            m_hold = m_hold - 1;
        end else if (tick) begin
            m_peak = nl;
        end
        m_level = nl;
        if (mag == 2047) m_clip = 1;
        else if (clip_clr) m_clip = 0;
    endtask

    // Drive one cycle of inputs, clock it, and sample just after the edge.
    task automatic applyStimulus(input logic r, input logic t, input logic v,
                                 input logic [11:0] s, input logic c);
        rst = r; tick = t; sample_valid = v; sample = s; clip_clr = c;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " level"}, int'(level), m_level);
        checkOutput({tag, " bar"}, int'(bar), m_bar);
        checkOutput({tag, " peak_led"}, int'(peak_led), m_led);
        checkOutput({tag, " clip"}, int'(clip), m_clip);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; sample_valid = 1'b0; sample = 12'd0; clip_clr = 1'b0;
        applyStimulus(1, 0, 0, 12'd0, 0);
        applyStimulus(1, 0, 0, 12'd0, 0);

        // Idle with ticks after reset: everything stays dark.
        for (int i = 0; i < 10; i++) applyStimulus(0, i[0], 0, 12'd0, 0);
        checkOutput("idle level", int'(level), 0);
        checkOutput("idle bar", int'(bar), 0);
        checkOutput("idle peak_led", int'(peak_led), 0);
        checkOutput("idle clip", int'(clip), 0);

        // Directed vectors: rst tick valid sample clr | level bar led clip
        vecs[0]  = '{0, 0, 1, 12'h800, 0, 11'd2047, 8'h00, 8'h00, 1};
        vecs[1]  = '{0, 0, 0, 12'h000, 0, 11'd2047, 8'hFF, 8'h80, 1};
        vecs[2]  = '{0, 0, 0, 12'h000, 1, 11'd2047, 8'hFF, 8'h80, 0};
        vecs[3]  = '{0, 0, 1, 12'h7FF, 1, 11'd2047, 8'hFF, 8'h80, 1};
        vecs[4]  = '{1, 1, 1, 12'h7FF, 0, 11'd0,    8'h00, 8'h00, 0};
        vecs[5]  = '{0, 0, 1, 12'd300, 0, 11'd300,  8'h00, 8'h00, 0};
        vecs[6]  = '{0, 1, 0, 12'd0,   0, 11'd284,  8'h03, 8'h02, 0};
        vecs[7]  = '{0, 1, 0, 12'd0,   0, 11'd268,  8'h03, 8'h02, 0};
        vecs[8]  = '{0, 1, 0, 12'd0,   0, 11'd252,  8'h03, 8'h02, 0};
        vecs[9]  = '{0, 0, 0, 12'd0,   0, 11'd252,  8'h01, 8'h02, 0};
        vecs[10] = '{0, 0, 1, 12'd510, 0, 11'd510,  8'h01, 8'h02, 0};
        vecs[11] = '{0, 1, 1, 12'd500, 0, 11'd500,  8'h03, 8'h02, 0};
        vecs[12] = '{0, 0, 0, 12'd0,   0, 11'd500,  8'h03, 8'h02, 0};
        vecs[13] = '{0, 0, 1, 12'd1200,0, 11'd1200, 8'h03, 8'h02, 0};
        vecs[14] = '{0, 0, 0, 12'd0,   0, 11'd1200, 8'h1F, 8'h10, 0};
        vecs[15] = '{1, 0, 1, 12'd900, 0, 11'd0,    8'h00, 8'h00, 0};
        vecs[16] = '{0, 0, 1, 12'd100, 0, 11'd100,  8'h00, 8'h00, 0};
        vecs[17] = '{0, 0, 0, 12'd0,   0, 11'd100,  8'h01, 8'h01, 0};
        vecs[18] = '{0, 0, 1, 12'hFFF, 0, 11'd100,  8'h01, 8'h01, 0};
        vecs[19] = '{0, 0, 1, 12'h801, 0, 11'd2047, 8'h01, 8'h01, 1};
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].valid, vecs[i].smp, vecs[i].clr);
            checkOutput($sformatf("vec%0d level", i), int'(level), int'(vecs[i].e_level));
            checkOutput($sformatf("vec%0d bar", i), int'(bar), int'(vecs[i].e_bar));
            checkOutput($sformatf("vec%0d peak_led", i), int'(peak_led), int'(vecs[i].e_led));
            checkOutput($sformatf("vec%0d clip", i), int'(clip), int'(vecs[i].e_clip));
        end

        // Decay all the way to zero without wrapping.
        applyStimulus(1, 0, 0, 12'd0, 0);
        applyStimulus(0, 0, 1, 12'd300, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 12'd0, 0);
        checkOutput("decay3 level", int'(level), 252);
        applyStimulus(0, 0, 0, 12'd0, 0);
        checkOutput("decay3 bar", int'(bar), 8'h01);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 12'd0, 0);
        checkOutput("decay19 level", int'(level), 0);
        applyStimulus(0, 1, 0, 12'd0, 0);
        checkOutput("decay floor level", int'(level), 0);
        checkOutput("decay floor bar", int'(bar), 8'h00);

        // Peak hold for 50 ticks, then the peak follows the level.
        applyStimulus(1, 0, 0, 12'd0, 0);
        applyStimulus(0, 0, 1, 12'd1000, 0);
        applyStimulus(0, 0, 0, 12'd0, 0);
        checkOutput("hold start peak_led", int'(peak_led), 8'h08);
        for (int i = 1; i <= 50; i++) begin
            applyStimulus(0, 1, 0, 12'd0, 0);
            checkOutput($sformatf("hold tick%0d peak_led", i), int'(peak_led), 8'h08);
        end
        checkOutput("hold50 level", int'(level), 200);
        checkOutput("hold50 bar", int'(bar), 8'h01);
        applyStimulus(0, 1, 0, 12'd0, 0);
        applyStimulus(0, 0, 0, 12'd0, 0);
        checkOutput("hold51 level", int'(level), 184);
        checkOutput("hold51 peak_led", int'(peak_led), 8'h01);
        checkOutput("hold51 bar", int'(bar), 8'h01);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [11:0] s;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      s = 12'h800;
            else if (sel == 1) s = 12'h7FF;
            else if (sel == 2) s = 12'h801;
            else               s = 12'($urandom);
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0), s, ($urandom_range(0, 7) == 0));
            checkModel($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
